// File: rtl/instr_mem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Response bundle carries the fetched word and its fault flag.
package instr_mem_responder_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } imem_rsp_t;

endpackage

// File: rtl/instr_mem_responder_rsp_fifo.sv
// Synchronous show-ahead FIFO of instruction responses.
// Flush empties it in one edge; contents are not reset.
module imem_rsp_fifo
  import instr_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  imem_rsp_t data_i,
  input  logic      pop_i,
  input  logic      flush_i,
  output imem_rsp_t data_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int AW = $clog2(DEPTH);

  imem_rsp_t    mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: fixed-latency word store read with
// credit-limited outstanding requests and an in-order response FIFO.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int    WORDS     = 1024,
  parameter int    LATENCY   = 1,
  parameter int    RSP_DEPTH = 4,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_mem_req_i,
  input  logic [63:0]              instr_mem_addr_i,
  output logic                     instr_mem_ready_o,
  input  logic                     instr_mem_flush_i,
  output logic [31:0]              fetch_instr_o,
  output logic                     instr_valid_o,
  output logic                     instr_fault_o,
  input  logic                     instr_rsp_ready_i,
  input  logic                     load_en_i,
  input  logic [$clog2(WORDS)-1:0] load_idx_i,
  input  logic [31:0]              load_data_i
);

  localparam int IW = $clog2(WORDS);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [31:0]        store_q [WORDS];
  logic [LATENCY-1:0] pv_q;
  imem_rsp_t          pipe_q [LATENCY];
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic               accept;
  logic               pop;
  logic               push;
  logic               empty;
  logic               full;
  logic               bad;
  logic [IW-1:0]      idx;
  imem_rsp_t          head;

  assign instr_mem_ready_o = (cnt_q < CW'(RSP_DEPTH));
  assign accept = instr_mem_req_i & instr_mem_ready_o;
  assign idx    = instr_mem_addr_i[2 +: IW];
  assign bad    = (|instr_mem_addr_i[1:0]) |
                  (|instr_mem_addr_i[63:IW+2]);

  assign push          = pv_q[LATENCY-1] & ~instr_mem_flush_i;
  assign instr_valid_o = ~empty & ~instr_mem_flush_i;
  assign pop           = instr_valid_o & instr_rsp_ready_i;
  assign fetch_instr_o = empty ? NOP_INSTR : head.instr;
  assign instr_fault_o = ~empty & head.fault;

  // Flush keeps only the new-path request accepted in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (instr_mem_flush_i) cnt_d = CW'(accept);
    else cnt_d = cnt_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (load_en_i) store_q[load_idx_i] <= load_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = LATENCY-1; i > 0; i--)
        pv_q[i] <= pv_q[i-1] & ~instr_mem_flush_i;
      pv_q[0] <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pipe_q[0].instr <= bad ? NOP_INSTR : store_q[idx];
      pipe_q[0].fault <= bad;
    end
    for (int i = LATENCY-1; i > 0; i--)
      pipe_q[i] <= pipe_q[i-1];
  end

  imem_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .data_i  (pipe_q[LATENCY-1]),
    .pop_i   (pop),
    .flush_i (instr_mem_flush_i),
    .data_o  (head),
    .empty_o (empty),
    .full_o  (full)
  );

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset) push |-> !full);
  a_cnt_bound: assert property (
    @(posedge clk) disable iff (reset) cnt_q <= CW'(RSP_DEPTH));

endmodule
